// File: rtl/nes_line_doubler.sv
// nes_line_doubler: doubles the 256x240 NES PPU stream to 512x480 RGB888 through ping-pong line buffers
// Ports: clk/reset (sync, active high); in_ce/in_x/in_y/in_color carry one PPU dot per in_ce;
// o_r/o_g/o_b are the palette-mapped pixel; o_h/o_v are the counters aligned with it; o_hs/o_vs are active-low syncs.
module nes_line_doubler #(
  parameter logic [10:0] H_TOTAL  = 11'd682,
  parameter logic [10:0] V_TOTAL  = 11'd524,
  parameter logic [10:0] HS_START = 11'd560,
  parameter logic [10:0] HS_END   = 11'd608,
  parameter logic [10:0] VS_START = 11'd490,
  parameter logic [10:0] VS_END   = 11'd492
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_ce,
  input  logic [8:0]  in_x,
  input  logic [8:0]  in_y,
  input  logic [5:0]  in_color,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic [10:0] o_h,
  output logic [10:0] o_v,
  output logic        o_hs,
  output logic        o_vs
);
  localparam logic [23:0] PAL [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };
  logic [5:0]  mem [512];
  logic [10:0] hc, vc, h1, v1, ly, lock_v;
  logic [5:0]  pix;
  logic        vis1, lock, we, h_end;
  always_comb begin
    lock   = in_ce && in_x == 9'd0;
    we     = in_ce && !in_x[8] && in_y < 9'd240;
    h_end  = hc == H_TOTAL - 11'd1;
    ly     = {1'b0, in_y, 1'b0} - 11'd2;
    // line y's first dot puts the output two lines behind it so line y-1's buffer replays during PPU line y
    lock_v = in_y == 9'd0 ? V_TOTAL - 11'd2 : ly >= V_TOTAL ? ly - V_TOTAL : ly;
  end
  always_ff @(posedge clk)
    if (we) mem[{in_y[0], in_x[7:0]}] <= in_color;
  always_ff @(posedge clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
      pix <= '0;
      h1 <= '0;
      v1 <= '0;
      vis1 <= 1'b0;
      {o_r, o_g, o_b} <= '0;
      o_h <= '0;
      o_v <= '0;
      o_hs <= 1'b1;
      o_vs <= 1'b1;
    end else begin
      hc <= lock || h_end ? 11'd0 : hc + 11'd1;
      vc <= lock ? lock_v : !h_end ? vc : vc == V_TOTAL - 11'd1 ? 11'd0 : vc + 11'd1;
      // hc[8:1] equals hc[9:1] wherever the read is visible
      pix <= mem[{vc[1], hc[8:1]}];
      h1 <= hc;
      v1 <= vc;
      vis1 <= hc < 11'd512 && vc < 11'd480;
      {o_r, o_g, o_b} <= vis1 ? PAL[pix] : 24'd0;
      o_h <= h1;
      o_v <= v1;
      o_hs <= !(h1 >= HS_START && h1 < HS_END);
      o_vs <= !(v1 >= VS_START && v1 < VS_END);
    end
  end
endmodule

// File: tb/tb_nes_line_doubler.sv
// tb_nes_line_doubler: random PPU line stimulus checked against a frame-position model of the doubler
module tb_nes_line_doubler;
  logic clk = 1'b0, reset = 1'b1, in_ce = 1'b0;
  logic [8:0] in_x = '0, in_y = '0;
  logic [5:0] in_color = '0;
  logic [7:0] o_r, o_g, o_b;
  logic [10:0] o_h, o_v;
  logic o_hs, o_vs;
  always #5 clk = ~clk;
  nes_line_doubler dut (
    .clk(clk), .reset(reset), .in_ce(in_ce), .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_h(o_h), .o_v(o_v), .o_hs(o_hs), .o_vs(o_vs)
  );
  localparam logic [23:0] PAL [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };
  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic [23:0] rgb;
    bit ok;
  } ent_t;
  ent_t s1, s2;
  int p, vectors, errs, hs_cnt, last_h;
  int mem [2][256];
  bit mval [2][256];
  bit started, pin2, pin5;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic ent_t look(int pp);
    ent_t e;
    int h, v;
    h = pp % 682;
    v = pp / 682;
    e.h = 11'(h);
    e.v = 11'(v);
    e.rgb = 24'd0;
    e.ok = 1'b1;
    if (h < 512 && v < 480) begin
      e.rgb = PAL[mem[(v / 2) % 2][h / 2]];
      e.ok = mval[(v / 2) % 2][h / 2];
    end
    return e;
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      s1 = '{11'd0, 11'd0, 24'd0, 1'b1};
      s2 = s1;
      p = 0;
      started = 1'b1;
    end else begin
      s2 = s1;
      s1 = look(p);
      if (in_ce && in_x < 256 && in_y < 240) begin
        mem[in_y % 2][in_x] = int'(in_color);
        mval[in_y % 2][in_x] = 1'b1;
      end
      p = (in_ce && in_x == 0) ? ((2 * int'(in_y) + 522) % 524) * 682 : (p + 1) % (682 * 524);
    end
  end
  always @(negedge clk) if (started) begin
    logic ehs, evs;
    ehs = !(s2.h >= 560 && s2.h < 608);
    evs = !(s2.v >= 490 && s2.v < 492);
    vectors++;
    if (o_h !== s2.h || o_v !== s2.v || o_hs !== ehs || o_vs !== evs || (s2.ok && {o_r, o_g, o_b} !== s2.rgb)) begin
      errs++;
      $display("FAIL stream t=%0t h=%0d/%0d v=%0d/%0d hs=%b/%b vs=%b/%b rgb=%h/%h", $time,
               o_h, s2.h, o_v, s2.v, o_hs, ehs, o_vs, evs, {o_r, o_g, o_b}, s2.rgb);
    end
    if (pin2 && o_v == 10 && o_h <= 1) chk("pal00", {o_r, o_g, o_b}, 24'h7C7C7C);
    if (pin2 && o_v == 10 && o_h == 30) chk("pal0F", {o_r, o_g, o_b}, 24'h000000);
    if (pin2 && (o_v == 10 || o_v == 11) && o_h == 97) chk("pal30", {o_r, o_g, o_b}, 24'hFCFCFC);
    if (o_h == 0) begin
      if (pin5 && last_h == 681) chk("hs_width", hs_cnt, 48);
      hs_cnt = 0;
    end
    if (!o_hs) hs_cnt++;
    last_h = int'(o_h);
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic dot(int x, int y, int c, int period);
    in_ce = 1'b1;
    in_x = 9'(x);
    in_y = 9'(y);
    in_color = 6'(c);
    tick(1);
    in_ce = 1'b0;
    tick(period - 1);
  endtask
  task automatic ppu_line(int y, int x0, int x1, bit ramp, int period);
    for (int x = x0; x < x1; x++) dot(x, y, ramp ? x : int'($urandom), period);
  endtask
  task automatic lock_check(int y, int ev);
    dot(0, y, int'($urandom), 1);
    tick(2);
    @(negedge clk);
    chk("lock_v", o_v, ev);
    chk("lock_h", o_h, 0);
    ppu_line(y, 1, 341, 1'b0, 4);
  endtask
  task automatic reset_check(string n);
    @(negedge clk);
    chk({n, "_rgb"}, {o_r, o_g, o_b}, 0);
    chk({n, "_hv"}, {o_h, o_v}, 0);
    chk({n, "_sync"}, {o_hs, o_vs}, 2'b11);
  endtask
  initial begin
    tick(3);
    reset_check("rst");
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    chk("rel_h0", o_h, 0);
    tick(2);
    @(negedge clk);
    chk("rel_h1", o_h, 1);
    dot(0, 0, 7, 1);
    tick(2);
    @(negedge clk);
    chk("y0_v", o_v, 522);
    tick(682);
    @(negedge clk);
    chk("v523", {o_h, o_v}, {11'd0, 11'd523});
    tick(682);
    @(negedge clk);
    chk("vwrap", {o_h, o_v}, {11'd0, 11'd0});
    ppu_line(4, 0, 341, 1'b0, 4);
    ppu_line(5, 0, 341, 1'b1, 4);
    pin2 = 1'b1;
    ppu_line(6, 0, 341, 1'b0, 4);
    pin2 = 1'b0;
    ppu_line(250, 0, 341, 1'b0, 4);
    ppu_line(251, 0, 341, 1'b0, 4);
    ppu_line(7, 0, 341, 1'b0, 4);
    ppu_line(8, 0, 341, 1'b0, 4);
    ppu_line(9, 0, 75, 1'b0, 4);
    tick(1);
    lock_check(10, 18);
    pin5 = 1'b1;
    ppu_line(11, 0, 341, 1'b0, 4);
    pin5 = 1'b0;
    ppu_line(12, 0, 25, 1'b0, 4);
    reset = 1'b1;
    tick(2);
    reset_check("midrst");
    reset = 1'b0;
    tick(5);
    lock_check(20, 38);
    lock_check(0, 522);
    repeat (24) begin
      int y, per, n;
      y = ($urandom % 4 == 0) ? int'($urandom_range(240, 261)) : int'($urandom_range(0, 239));
      per = ($urandom % 4 == 0) ? int'($urandom_range(3, 5)) : 4;
      n = ($urandom % 5 == 0) ? int'($urandom_range(1, 340)) : 341;
      ppu_line(y, 0, n, 1'b0, per);
      if ($urandom % 4 == 0) tick(int'($urandom_range(0, 800)));
    end
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
  initial begin
    #1500000;
    errs++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
